// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder stepped LSB-first over WIDTH cycles,
// with a valid/ready handshake on the operand side and on the result side.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               fa_s, fa_co;

    full_adder u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = WIDTH'({fa_s, sum_sh_q} >> 1);
                carry_d  = fa_co;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last bit: publish the result so sum/c_out change only on entry to DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    sum_d   = sum_sh_d;
                    c_out_d = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed and random operations on a WIDTH=8 instance,
// plus an exhaustive sweep of a WIDTH=4 instance, all against plain-arithmetic expectations.

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, c_in8, out_valid8, out_ready8, c_out8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4, busy4;
    logic [3:0] a4, b4, sum4;

    int checks;
    int errors;
    int cyc;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .c_in      (c_in8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .c_out     (c_out8),
        .busy      (busy8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .c_in      (c_in4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .c_out     (c_out4),
        .busy      (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; hold cycles of out_ready=0 in DONE, optionally pulsing new operands.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input int hold, input bit pulse);
        logic [8:0] exp;
        int n;
        exp = 9'(av) + 9'(bv) + 9'(cv);
        n = 0;
        while (!in_ready8 && n < 20) begin step(); n++; end
        chk("op8_ready_before_accept", 16'(in_ready8), 16'd1);
        a8 = av; b8 = bv; c_in8 = cv; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
        n = 0;
        while (!out_valid8 && n < 20) begin step(); n++; end
        chk("op8_latency", 16'(n), 16'd8);
        chk("op8_result", 16'({c_out8, sum8}), 16'(exp));
        chk("op8_busy_done", 16'(busy8), 16'd1);
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid8 = (i % 2) == 0;
                a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
            end
            step();
            chk("hold_out_valid", 16'(out_valid8), 16'd1);
            chk("hold_result", 16'({c_out8, sum8}), 16'(exp));
            chk("hold_in_ready", 16'(in_ready8), 16'd0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        chk("after_ack_in_ready", 16'(in_ready8), 16'd1);
        chk("after_ack_out_valid", 16'(out_valid8), 16'd0);
        chk("after_ack_busy", 16'(busy8), 16'd0);
        chk("idle_keeps_result", 16'({c_out8, sum8}), 16'(exp));
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        logic [4:0] exp;
        int n;
        exp = 5'(av) + 5'(bv) + 5'(cv);
        n = 0;
        while (!in_ready4 && n < 20) begin step(); n++; end
        a4 = av; b4 = bv; c_in4 = cv; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin step(); n++; end
        checks++;
        assert (n == 4 && !({c_out4, sum4} !== exp)) else begin
            errors++;
            $error("FAIL w4_%0h_%0h_%0h observed=%0h latency=%0d expected=%0h latency=4",
                   av, bv, cv, {c_out4, sum4}, n, exp);
        end
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic [8:0] exp;
        int n;
        int last_acc;
        clk = 1'b0; cyc = 0; checks = 0; errors = 0;
        in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0; c_in8 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0; c_in4 = 0;
        rst = 1'b1;
        #2;
        chk("rst_in_ready", 16'(in_ready8), 16'd1);
        chk("rst_out_valid", 16'(out_valid8), 16'd0);
        chk("rst_busy", 16'(busy8), 16'd0);
        chk("rst_result", 16'({c_out8, sum8}), 16'd0);
        step(); step();
        rst = 1'b0;
        step();

        op8(8'h5A, 8'h33, 1'b0, 0, 0);
        op8(8'hFF, 8'h01, 1'b0, 0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 0, 0);
        op8(8'h00, 8'h00, 1'b0, 0, 0);
        op8(8'h12, 8'h34, 1'b1, 5, 1);

        // Reset partway through RUN aborts cleanly.
        a8 = 8'hC3; b8 = 8'h7E; c_in8 = 1'b1; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step(); step(); step();
        chk("run_busy", 16'(busy8), 16'd1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 16'(out_valid8), 16'd0);
        chk("abort_busy", 16'(busy8), 16'd0);
        chk("abort_in_ready", 16'(in_ready8), 16'd1);
        chk("abort_result", 16'({c_out8, sum8}), 16'd0);
        step();
        rst = 1'b0;
        step();
        op8(8'h10, 8'h20, 1'b1, 0, 0);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Back-to-back with in_valid and out_ready held high.
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
        last_acc = 0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!in_ready8 && n < 20) begin step(); n++; end
            exp = 9'(a8) + 9'(b8) + 9'(c_in8);
            if (k > 0) chk("b2b_spacing", 16'(cyc - last_acc), 16'd10);
            last_acc = cyc;
            step();
            a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom);
            n = 0;
            while (!out_valid8 && n < 20) begin step(); n++; end
            chk("b2b_result", 16'({c_out8, sum8}), 16'(exp));
            step();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        step();

        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    op4(4'(av), 4'(bv), 1'(cv));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
